// File: rtl/encode_16_4_seq.sv
// Sequential 16-to-4 encoder: captures a multi-hot request vector and emits one set index per
// accepted handshake. Optional macro ENC_MERGE_EN lets loads during SCAN merge into the pending set.
module encode_16_4_seq #(
   parameter int unsigned N       = 16,
   parameter int unsigned W       = 4,
   parameter int unsigned LSB_PRI = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_in,
   input  logic         load,
   input  logic         ready_in,
   output logic [W-1:0] e_out,
   output logic         valid,
   output logic         busy,
   output logic         done,
   output logic         none
);

   typedef enum logic [0:0] {StIdle, StScan} state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   pending_q, pending_d;
   logic [W-1:0]   e_out_q, e_out_d;
   logic           valid_q, valid_d;
   logic           done_q, done_d;
   logic           none_q, none_d;

   logic           fire;
   logic [N-1:0]   rem;
   logic [N-1:0]   merged;

   // Last matching write wins, so scan away from the preferred end.
   function automatic logic [W-1:0] pri(input logic [N-1:0] v);
      logic [W-1:0] idx;
      int unsigned  j;
      idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         j = (LSB_PRI != 0) ? (N - 1 - i) : i;
         if (v[j]) idx = W'(j);
      end
      return idx;
   endfunction

   assign fire = valid_q & ready_in;
   assign rem  = pending_q & ~(N'(1) << e_out_q);

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      e_out_d   = e_out_q;
      valid_d   = valid_q;
      done_d    = 1'b0;
      none_d    = 1'b0;
      merged    = pending_q;
      unique case (state_q)
         StIdle: begin
            if (load) begin
               if (|req_in) begin
                  pending_d = req_in;
                  e_out_d   = pri(req_in);
                  valid_d   = 1'b1;
                  state_d   = StScan;
               end else begin
                  none_d = 1'b1;
               end
            end
         end
         StScan: begin
            if (fire) merged = rem;
`ifdef ENC_MERGE_EN
            if (load) merged = merged | req_in;
`endif
            pending_d = merged;
            // e_out only advances on a fire so a stalled output stays stable.
            if (fire) begin
               if (|merged) begin
                  e_out_d = pri(merged);
               end else begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         pending_q <= '0;
         e_out_q   <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         none_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         e_out_q   <= e_out_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         none_q    <= none_d;
      end
   end

   assign e_out = e_out_q;
   assign valid = valid_q;
   assign busy  = (state_q == StScan);
   assign done  = done_q;
   assign none  = none_q;

endmodule

// File: tb/tb_encode_16_4_seq.sv
// Scoreboard bench for encode_16_4_seq: expected indices are queued in ascending order from the
// request sets; a negedge monitor checks every cycle against the queue.
module tb_encode_16_4_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] req_in = '0;
   logic        load = 1'b0;
   logic        ready_in = 1'b0;
   logic [3:0]  e_out;
   logic        valid, busy, done, none;

   encode_16_4_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_in   (req_in),
      .load     (load),
      .ready_in (ready_in),
      .e_out    (e_out),
      .valid    (valid),
      .busy     (busy),
      .done     (done),
      .none     (none)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int exp_q[$];
   int seen[$];
   bit done_exp = 0;
   bit none_exp = 0;
   bit fired = 0;
   int nfires = 0;
   int ndone = 0;
   int nnone = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] q_mask();
      logic [15:0] m = '0;
      foreach (exp_q[i]) m[exp_q[i]] = 1'b1;
      return m;
   endfunction

   // Ascending index order of a set, skipping one index (-1 skips none).
   task automatic fill(input logic [15:0] m, input int skip);
      for (int i = 0; i < 16; i++) if (m[i] && i != skip) exp_q.push_back(i);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("valid_vs_model", int'(valid), int'(exp_q.size() != 0));
         chk("busy_vs_model", int'(busy), int'(exp_q.size() != 0));
         chk("done_pulse", int'(done), int'(done_exp));
         chk("none_pulse", int'(none), int'(none_exp));
         if (done) ndone++;
         if (none) nnone++;
         done_exp = 0;
         none_exp = 0;
         if (valid && exp_q.size() != 0) chk("e_out", int'(e_out), exp_q[0]);
         fired = valid && ready_in;
         if (fired) begin
            nfires++;
            seen.push_back(int'(e_out));
            if (exp_q.size() != 0) begin
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) done_exp = 1;
            end
         end
      end
   end

   task automatic apply_load(input bit idle, input logic [15:0] rq);
      logic [15:0] m;
      int head;
      if (idle) begin
         if (rq == 0) none_exp = 1;
         else fill(rq, -1);
      end else begin
`ifdef ENC_MERGE_EN
         if (fired) begin
            m = q_mask() | rq;
            exp_q.delete();
            fill(m, -1);
            if (exp_q.size() != 0) done_exp = 0;
         end else begin
            head = exp_q[0];
            m = q_mask() | rq;
            exp_q.delete();
            exp_q.push_back(head);
            fill(m, head);
         end
`else
         m = rq;
`endif
      end
   endtask

   // Called at posedge+1; drives inputs for one cycle, then updates the model.
   task automatic cycle(input logic ld, input logic [15:0] rq, input logic rdy);
      bit idle_now;
      idle_now = (exp_q.size() == 0);
      load = ld;
      req_in = rq;
      ready_in = rdy;
      @(posedge clk);
      #1;
      load = 1'b0;
      if (ld) apply_load(idle_now, rq);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         cycle(1'b0, 16'h0, 1'b1);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
      cycle(1'b0, 16'h0, 1'b1);
      cycle(1'b0, 16'h0, 1'b1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_e_out"}, int'(e_out), 0);
      chk({tag, "_valid"}, int'(valid), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_none"}, int'(none), 0);
   endtask

   initial begin
      int d0, f0, n0, k;
      logic [15:0] r;
      #1 rst_n = 1'b0;
      #2 chk_zero("rst");
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1 chk_zero("post_rst");

      // 8421 with ready held high
      seen.delete();
      d0 = ndone;
      cycle(1'b1, 16'h8421, 1'b1);
      drain();
      chk("t2_count", seen.size(), 4);
      if (seen.size() == 4) begin
         chk("t2_idx0", seen[0], 0);
         chk("t2_idx1", seen[1], 5);
         chk("t2_idx2", seen[2], 10);
         chk("t2_idx3", seen[3], 15);
      end
      chk("t2_done", ndone - d0, 1);

      // 0011 with ready stalled for 3 cycles
      seen.delete();
      cycle(1'b1, 16'h0011, 1'b0);
      repeat (3) cycle(1'b0, 16'h0, 1'b0);
      chk("t3_hold_e_out", int'(e_out), 0);
      chk("t3_hold_valid", int'(valid), 1);
      drain();
      chk("t3_count", seen.size(), 2);
      if (seen.size() == 2) chk("t3_second", seen[1], 4);

      // zero vector in IDLE
      n0 = nnone;
      cycle(1'b1, 16'h0, 1'b1);
      repeat (3) cycle(1'b0, 16'h0, 1'b1);
      chk("t4_none_count", nnone - n0, 1);

      // FFFF interrupted by reset after two fires
      f0 = nfires;
      cycle(1'b1, 16'hFFFF, 1'b1);
      k = 0;
      while (nfires < f0 + 2 && k < 50) begin
         cycle(1'b0, 16'h0, 1'b1);
         k++;
      end
      chk("t5_fires", nfires - f0, 2);
      #2 rst_n = 1'b0;
      #1 chk_zero("t5_rst");
      exp_q.delete();
      done_exp = 0;
      none_exp = 0;
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      seen.delete();
      cycle(1'b1, 16'h0002, 1'b1);
      drain();
      chk("t5_count", seen.size(), 1);
      if (seen.size() == 1) chk("t5_idx", seen[0], 1);

      // load during the first fire cycle
      seen.delete();
      d0 = ndone;
      cycle(1'b1, 16'h0003, 1'b1);
      cycle(1'b1, 16'h0100, 1'b1);
      drain();
`ifdef ENC_MERGE_EN
      chk("t6_count", seen.size(), 3);
      if (seen.size() == 3) chk("t6_last", seen[2], 8);
`else
      chk("t6_count", seen.size(), 2);
      if (seen.size() == 2) chk("t6_last", seen[1], 1);
`endif
      chk("t6_done", ndone - d0, 1);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0: r = 16'h0;
            1: r = 16'($urandom);
            default: r = 16'($urandom & $urandom & $urandom);
         endcase
         cycle(($urandom_range(0, 9) < 3), r, ($urandom_range(0, 9) < 7));
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
